// File: rtl/wbc_iak_pkg.sv
// Shared definitions for the Wishbone interrupt-acknowledge initiator:
// state encoding, default vector mask and guard length.
package wbc_iak_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSTB  = 3'd1,
        ST_VRDY  = 3'd2,
        ST_USTB  = 3'd3,
        ST_GUARD = 3'd4
    } state_t;

    localparam logic [15:0] VMSK_DEF  = 16'o000774;
    localparam int unsigned GUARD_LEN = 2;
    localparam int unsigned CNT_W     = 8;

    // True for the two states that drive the strobe toward the controller.
    function automatic logic is_strobe(input state_t st);
        return (st == ST_VSTB) || (st == ST_USTB);
    endfunction

endpackage

// File: rtl/wbc_iak.sv
// Interrupt-acknowledge / unaddressed-read initiator between the core's trap
// sequencer and the vectored interrupt controller; all outputs registered.
module wbc_iak
    import wbc_iak_pkg::*;
#(
    parameter int          TOUT = 16,
    parameter logic [15:0] VMSK = VMSK_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_irq_i,
    output logic        wb_stb_o,
    output logic        wb_una_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        cpu_ena_i,
    output logic        cpu_req_o,
    output logic [15:0] cpu_vec_o,
    input  logic        cpu_ack_i,
    input  logic        una_req_i,
    output logic [15:0] una_dat_o,
    output logic        una_rdy_o,
    output logic        err_o
);

    // Last strobe clock before timeout, and the saturation ceiling.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TOUT - 1);
    localparam logic [CNT_W-1:0] TMO_SAT  = CNT_W'(TOUT);
    localparam logic [1:0]       GRD_LAST = 2'(GUARD_LEN - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   tmo_cnt_r;
    logic [CNT_W-1:0]   tmo_nxt_s;
    logic [1:0]         grd_cnt_r;
    logic [1:0]         grd_nxt_s;

    logic               stb_r;
    logic               una_r;
    logic               req_r;
    logic               rdy_r;
    logic               err_r;
    logic [15:0]        vec_r;
    logic [15:0]        udat_r;

    logic               stb_nxt_s;
    logic               una_nxt_s;
    logic               req_nxt_s;
    logic               rdy_nxt_s;
    logic               err_nxt_s;
    logic [15:0]        vec_nxt_s;
    logic [15:0]        udat_nxt_s;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_nxt_s = state_r;
        tmo_nxt_s   = tmo_cnt_r;
        grd_nxt_s   = grd_cnt_r;
        vec_nxt_s   = vec_r;
        udat_nxt_s  = udat_r;
        rdy_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                grd_nxt_s = 2'd0;
                tmo_nxt_s = {CNT_W{1'b0}};
                // A pending unaddressed read takes priority over the interrupt.
                if (una_req_i) begin
                    state_nxt_s = ST_USTB;
                end else if (wb_irq_i && cpu_ena_i) begin
                    state_nxt_s = ST_VSTB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_VSTB: begin
                if (wb_ack_i) begin
                    vec_nxt_s   = wb_dat_i & VMSK;
                    state_nxt_s = ST_VRDY;
                end else if (tmo_cnt_r >= TMO_LAST) begin
                    err_nxt_s   = 1'b1;
                    grd_nxt_s   = 2'd0;
                    state_nxt_s = ST_GUARD;
                end else if (tmo_cnt_r < TMO_SAT) begin
                    tmo_nxt_s   = tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    tmo_nxt_s   = tmo_cnt_r;
                end
            end

            ST_VRDY: begin
                if (cpu_ack_i) begin
                    grd_nxt_s   = 2'd0;
                    state_nxt_s = ST_GUARD;
                end else begin
                    state_nxt_s = ST_VRDY;
                end
            end

            ST_USTB: begin
                if (wb_ack_i) begin
                    udat_nxt_s  = wb_dat_i;
                    rdy_nxt_s   = 1'b1;
                    grd_nxt_s   = 2'd0;
                    state_nxt_s = ST_GUARD;
                end else if (tmo_cnt_r >= TMO_LAST) begin
                    err_nxt_s   = 1'b1;
                    grd_nxt_s   = 2'd0;
                    state_nxt_s = ST_GUARD;
                end else if (tmo_cnt_r < TMO_SAT) begin
                    tmo_nxt_s   = tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    tmo_nxt_s   = tmo_cnt_r;
                end
            end

            ST_GUARD: begin
                // Request line is deliberately not looked at while the controller re-arbitrates.
                if (grd_cnt_r == GRD_LAST) begin
                    grd_nxt_s   = 2'd0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    grd_nxt_s   = grd_cnt_r + 2'd1;
                    state_nxt_s = ST_GUARD;
                end
            end

            default: begin
                grd_nxt_s   = 2'd0;
                tmo_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase

        stb_nxt_s = is_strobe(state_nxt_s);
        una_nxt_s = (state_nxt_s == ST_USTB);
        req_nxt_s = (state_nxt_s == ST_VRDY);
    end

    // State, counters and all outputs; reset clears everything immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_IDLE;
            tmo_cnt_r <= {CNT_W{1'b0}};
            grd_cnt_r <= 2'd0;
            stb_r     <= 1'b0;
            una_r     <= 1'b0;
            req_r     <= 1'b0;
            rdy_r     <= 1'b0;
            err_r     <= 1'b0;
            vec_r     <= 16'h0000;
            udat_r    <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            tmo_cnt_r <= tmo_nxt_s;
            grd_cnt_r <= grd_nxt_s;
            stb_r     <= stb_nxt_s;
            una_r     <= una_nxt_s;
            req_r     <= req_nxt_s;
            rdy_r     <= rdy_nxt_s;
            err_r     <= err_nxt_s;
            vec_r     <= vec_nxt_s;
            udat_r    <= udat_nxt_s;
        end
    end

    assign wb_stb_o  = stb_r;
    assign wb_una_o  = una_r;
    assign cpu_req_o = req_r;
    assign cpu_vec_o = vec_r;
    assign una_dat_o = udat_r;
    assign una_rdy_o = rdy_r;
    assign err_o     = err_r;

endmodule

// File: tb/tb_wbc_iak.sv
// Directed bench for wbc_iak: table of single transactions plus hand-written
// sequences for gating, priority, timeout, reset and queued requests.
module tb_wbc_iak;

    logic        clk;
    logic        wb_rst_i;
    logic        wb_irq_i;
    logic        wb_stb_o;
    logic        wb_una_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;
    logic        cpu_ena_i;
    logic        cpu_req_o;
    logic [15:0] cpu_vec_o;
    logic        cpu_ack_i;
    logic        una_req_i;
    logic [15:0] una_dat_o;
    logic        una_rdy_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    wbc_iak #(.TOUT(16), .VMSK(16'o000774)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .wb_irq_i  (wb_irq_i),
        .wb_stb_o  (wb_stb_o),
        .wb_una_o  (wb_una_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .cpu_ena_i (cpu_ena_i),
        .cpu_req_o (cpu_req_o),
        .cpu_vec_o (cpu_vec_o),
        .cpu_ack_i (cpu_ack_i),
        .una_req_i (una_req_i),
        .una_dat_o (una_dat_o),
        .una_rdy_o (una_rdy_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_una;
        logic [15:0] dat;
        int          ack_dly;   // strobe clocks before ack; >= 16 means never
        logic [15:0] exp_dat;
        int          exp_len;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
        chk({name, "_una"}, {31'd0, wb_una_o}, 32'd0);
        chk({name, "_req"}, {31'd0, cpu_req_o}, 32'd0);
        chk({name, "_rdy"}, {31'd0, una_rdy_o}, 32'd0);
        chk({name, "_err"}, {31'd0, err_o}, 32'd0);
        chk({name, "_vec"}, {16'd0, cpu_vec_o}, 32'd0);
        chk({name, "_udat"}, {16'd0, una_dat_o}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int low;
        @(negedge clk);
        if (v.is_una) begin
            una_req_i = 1'b1;
        end else begin
            wb_irq_i  = 1'b1;
            cpu_ena_i = 1'b1;
        end
        @(negedge clk);
        chk("stb_start", {31'd0, wb_stb_o}, 32'd1);
        n = 0;
        while (wb_stb_o && n < 40) begin
            n++;
            chk("una_tag", {31'd0, wb_una_o}, {31'd0, v.is_una});
            if (n - 1 == v.ack_dly) begin
                wb_ack_i = 1'b1;
                wb_dat_i = v.dat;
            end else begin
                wb_ack_i = 1'b0;
                wb_dat_i = 16'hBEEF;
            end
            @(negedge clk);
        end
        wb_ack_i  = 1'b0;
        wb_irq_i  = 1'b0;
        una_req_i = 1'b0;
        chk("stb_len", n, v.exp_len);
        chk("err", {31'd0, err_o}, {31'd0, v.exp_err});
        chk("req", {31'd0, cpu_req_o}, {31'd0, (!v.is_una && !v.exp_err)});
        chk("rdy", {31'd0, una_rdy_o}, {31'd0, (v.is_una && !v.exp_err)});
        if (v.is_una) chk("una_dat", {16'd0, una_dat_o}, {16'd0, v.exp_dat});
        else          chk("cpu_vec", {16'd0, cpu_vec_o}, {16'd0, v.exp_dat});
        @(negedge clk);
        chk("pulse_err", {31'd0, err_o}, 32'd0);
        chk("pulse_rdy", {31'd0, una_rdy_o}, 32'd0);
        if (!v.is_una && !v.exp_err) begin
            chk("req_hold", {31'd0, cpu_req_o}, 32'd1);
            cpu_ack_i = 1'b1;
            @(negedge clk);
            cpu_ack_i = 1'b0;
            chk("req_drop", {31'd0, cpu_req_o}, 32'd0);
        end
        low = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!wb_stb_o) low++;
        end
        chk("quiet_after", low, 4);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low;
        int errs;
        int reqs;
        int pend;
        int ack_hold;
        int vecs;
        logic prev_stb;
        logic prev_req;
        logic seen_first;

        tbl[0] = '{1'b0, 16'o000065, 1,  16'o000064, 2,  1'b0};
        tbl[1] = '{1'b0, 16'hFFFF,   0,  16'o000774, 1,  1'b0};
        tbl[2] = '{1'b1, 16'h1234,   1,  16'h1234,   2,  1'b0};
        tbl[3] = '{1'b1, 16'hA5C3,   3,  16'hA5C3,   4,  1'b0};
        tbl[4] = '{1'b0, 16'o000013, 14, 16'o000010, 15, 1'b0};
        tbl[5] = '{1'b0, 16'o123456, 15, 16'o000454, 16, 1'b0};
        tbl[6] = '{1'b0, 16'o000001, 99, 16'o000454, 16, 1'b1};
        tbl[7] = '{1'b1, 16'hFFFF,   99, 16'hA5C3,   16, 1'b1};

        wb_rst_i  = 1'b1;
        wb_irq_i  = 1'b0;
        wb_dat_i  = 16'h0000;
        wb_ack_i  = 1'b0;
        cpu_ena_i = 1'b0;
        cpu_ack_i = 1'b0;
        una_req_i = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Interrupt held off by cpu_ena_i, then taken the clock after enable.
        wb_irq_i  = 1'b1;
        cpu_ena_i = 1'b0;
        low = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!wb_stb_o) low++;
        end
        chk("ena_gate", low, 5);
        cpu_ena_i = 1'b1;
        @(negedge clk);
        chk("ena_stb", {31'd0, wb_stb_o}, 32'd1);
        cpu_ena_i = 1'b0;
        wb_ack_i  = 1'b1;
        wb_dat_i  = 16'o000200;
        @(negedge clk);
        wb_ack_i  = 1'b0;
        wb_irq_i  = 1'b0;
        chk("ena_drop_req", {31'd0, cpu_req_o}, 32'd1);
        chk("ena_drop_vec", {16'd0, cpu_vec_o}, {16'd0, 16'o000200});
        cpu_ack_i = 1'b1;
        @(negedge clk);
        cpu_ack_i = 1'b0;
        repeat (5) @(negedge clk);

        // Unaddressed read beats a simultaneous interrupt; vector follows the guard.
        wb_irq_i  = 1'b1;
        cpu_ena_i = 1'b1;
        una_req_i = 1'b1;
        @(negedge clk);
        chk("prio_stb", {31'd0, wb_stb_o}, 32'd1);
        chk("prio_una", {31'd0, wb_una_o}, 32'd1);
        wb_ack_i  = 1'b1;
        wb_dat_i  = 16'h1234;
        @(negedge clk);
        wb_ack_i  = 1'b0;
        una_req_i = 1'b0;
        chk("prio_rdy", {31'd0, una_rdy_o}, 32'd1);
        chk("prio_udat", {16'd0, una_dat_o}, {16'd0, 16'h1234});
        chk("prio_noreq", {31'd0, cpu_req_o}, 32'd0);
        low = 0;
        while (!wb_stb_o && low < 10) begin
            low++;
            @(negedge clk);
        end
        chk("prio_gap", low, 3);
        chk("prio_vtag", {31'd0, wb_una_o}, 32'd0);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'o000065;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_irq_i = 1'b0;
        chk("prio_vreq", {31'd0, cpu_req_o}, 32'd1);
        chk("prio_vec", {16'd0, cpu_vec_o}, {16'd0, 16'o000064});
        cpu_ack_i = 1'b1;
        @(negedge clk);
        cpu_ack_i = 1'b0;
        repeat (5) @(negedge clk);

        // Timeout with the request held: 16 strobe clocks, one err, 2 guard + idle.
        wb_irq_i = 1'b1;
        @(negedge clk);
        n = 0; errs = 0; reqs = 0;
        while (wb_stb_o && n < 40) begin
            n++;
            errs += int'(err_o);
            reqs += int'(cpu_req_o);
            @(negedge clk);
        end
        chk("tmo_len", n, 16);
        chk("tmo_err_now", {31'd0, err_o}, 32'd1);
        low = 0;
        while (!wb_stb_o && low < 10) begin
            errs += int'(err_o);
            reqs += int'(cpu_req_o);
            low++;
            @(negedge clk);
        end
        chk("tmo_err_once", errs, 1);
        chk("tmo_no_req", reqs, 0);
        chk("tmo_gap", low, 3);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'o000065;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_irq_i = 1'b0;
        chk("tmo_retry_vec", {16'd0, cpu_vec_o}, {16'd0, 16'o000064});
        cpu_ack_i = 1'b1;
        @(negedge clk);
        cpu_ack_i = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset in VSTB and then in VRDY.
        wb_irq_i = 1'b1;
        @(negedge clk);
        chk("rst_v_stb", {31'd0, wb_stb_o}, 32'd1);
        #2 wb_rst_i = 1'b1;
        #1 chk_all_zero("rst_vstb");
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);
        chk("rst_restart", {31'd0, wb_stb_o}, 32'd1);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'o000065;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk("rst_vrdy_req", {31'd0, cpu_req_o}, 32'd1);
        #2 wb_rst_i = 1'b1;
        #1 chk_all_zero("rst_vrdy");
        @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);
        chk("rst_restart2", {31'd0, wb_stb_o}, 32'd1);
        wb_ack_i = 1'b1;
        wb_dat_i = 16'o000377;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_irq_i = 1'b0;
        chk("rst_fresh_req", {31'd0, cpu_req_o}, 32'd1);
        chk("rst_fresh_vec", {16'd0, cpu_vec_o}, {16'd0, 16'o000374});
        cpu_ack_i = 1'b1;
        @(negedge clk);
        cpu_ack_i = 1'b0;
        repeat (5) @(negedge clk);

        // Two queued requests; controller acks one clock late and holds ack one extra clock.
        pend = 2; ack_hold = 0; vecs = 0;
        prev_stb = 1'b0; prev_req = 1'b0; seen_first = 1'b0;
        cpu_ena_i = 1'b1;
        wb_irq_i  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (wb_stb_o && !prev_stb && seen_first) chk("q_gap_ge2", {31'd0, (low >= 2)}, 32'd1);
            if (wb_stb_o) begin
                seen_first = 1'b1;
                low = 0;
            end else begin
                low++;
            end
            if (cpu_req_o && !prev_req) begin
                vecs++;
                chk("q_vec", {16'd0, cpu_vec_o}, (vecs == 1) ? 32'o000100 : 32'o000104);
            end
            cpu_ack_i = cpu_req_o;
            if (wb_stb_o && prev_stb && !wb_ack_i && pend > 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = (pend == 2) ? 16'o000101 : 16'o000107;
                pend--;
                ack_hold = 1;
            end else if (ack_hold > 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 16'o000777;
                ack_hold = 0;
            end else begin
                wb_ack_i = 1'b0;
            end
            wb_irq_i = (pend > 0);
            prev_stb = wb_stb_o;
            prev_req = cpu_req_o;
        end
        wb_ack_i  = 1'b0;
        cpu_ack_i = 1'b0;
        chk("q_count", vecs, 2);
        chk("q_final_vec", {16'd0, cpu_vec_o}, {16'd0, 16'o000104});
        chk("q_idle", {31'd0, wb_stb_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
